sc_prod_ctr: RTL and testbench
==============================

Name: sc_prod_ctr

Overview:
- Downstream consumer of the CAPE bitstream generators (plain, correlated and early-terminated variants).
- Each cycle it combines the NUM_INPUTS generated stream bits with a fixed SC operator (AND = multiply, OR, XOR = |a-b| for correlated pairs) and counts the ones.
- On each generator done pulse it captures the accumulated count as the binary result of the finished period.
- It presents that result on a valid/ready output port.

Parameters:
- NUM_INPUTS, 8, number of stream bits per cycle (must be >= 1; MODE 2 requires 2).
- CNT_WIDTH, 16, width of the ones counter and of the result.
- MODE, 0, combine operator: 0 AND of all bits, 1 OR of all bits, 2 XOR of bit0 and bit1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  stream bit valid; when low, the current bit is not counted.
- Xs  input  NUM_INPUTS  stream bits from the generator.
- done  input  1  one-cycle pulse from the generator; asserted in the cycle holding the first bit of a new period.
- clr  input  1  synchronous clear of acc, the result register and overrun.
- out_ready  input  1  consumer accepts the result.
- out_valid  output  1  result available.
- out_cnt  output  CNT_WIDTH  ones count of the last completed period.
- overrun  output  1  sticky; a completed result was dropped.

Behaviour:
- Reset (async, rst_n low): acc=0, out_cnt=0, out_valid=0, overrun=0. Clear is immediate and does not depend on clk.
- Combined bit b:
  - MODE0: b = &Xs.
  - MODE1: b = |Xs.
  - MODE2: b = Xs[0]^Xs[1].
  - inc = b & en.
- Accumulator, normal cycle (done=0): acc <= acc + inc.
  - Saturates at all-ones (2^CNT_WIDTH-1), never wraps.
- Accumulator, done cycle (done=1): the current bit belongs to the new period.
  - capture value = acc, excluding the current bit.
  - acc <= inc, so the new period starts with the current bit.
- Output register, on a capture:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: out_cnt <= capture value, out_valid <= 1 on the next edge.
  - Otherwise: out_cnt holds its old value, out_valid stays 1, overrun <= 1, and the new result is discarded.
- Handshake:
  - Transfer occurs on any edge with out_valid & out_ready.
  - Without a simultaneous capture: out_valid <= 0 and out_cnt holds its value.
  - out_cnt is stable whenever out_valid=1 and out_ready=0.
- Latency: done at edge-cycle t -> out_valid=1 and out_cnt valid in cycle t+1.
- Back-to-back done pulses (period length 1):
  - Each captures the prior acc, which is 0 or 1.
  - Normal handshake and overrun rules apply.
- clr:
  - Priority over done, over handshake and over counting.
  - Next state: acc=0, out_valid=0, out_cnt=0, overrun=0.
  - A done in the same cycle is lost and inc is not counted.
- First period after reset/clr: counting starts at the first cycle with rst_n high.
  - The first done captures the ones counted from that cycle.
- en=0 with done=1: capture still happens and acc <= 0.
- Reset mid-period: the partial count is lost, with no capture and no out_valid.
- overrun is cleared only by rst_n or clr.

Optional Feature:
- Macro: SC_PROD_CYCLE_CNT_EN.
- Defined:
  - Adds output out_len [CNT_WIDTH], the count of en-qualified cycles in the captured period.
  - Saturating; captured, held and handshaken together with out_cnt; reset/clr to 0.
  - Lets the consumer normalise early-terminated (shortened) periods as out_cnt/out_len.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- MODE0, NUM_INPUTS=2, period 256, bit0 high 128 of 256 cycles, bit1 high 64 of those 128, en=1, out_ready=1 -> out_cnt=64 one cycle after done, out_valid high 1 cycle, overrun=0.
- MODE1, bits all 0 except Xs[0]=1 on the done cycle only -> first capture out_cnt=0; next period's capture includes that bit -> out_cnt=1.
- out_ready=0 across two done pulses with counts 10 then 20 -> out_cnt stays 10, overrun=1 after second done; raise out_ready -> transfer, out_valid=0, overrun stays 1 until clr.
- CNT_WIDTH=4, 20 one-bits in a period -> out_cnt=15 (saturated); with SC_PROD_CYCLE_CNT_EN, out_len=15.
- clr and done asserted together after 5 counted ones -> out_valid stays 0, acc=0, next period counted from 0.
- rst_n dropped asynchronously mid-period with out_valid=1 -> out_valid=0, out_cnt=0, overrun=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sc_prod_ctr.sv
// Stochastic-computing product counter: combines generator stream bits, counts ones
// per period, and presents each period's count on a valid/ready port.
// Optional: define SC_PROD_CYCLE_CNT_EN to add out_len (en-qualified cycles per period).
module sc_prod_ctr #(
    parameter int NUM_INPUTS = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_INPUTS-1:0] Xs,
    input  logic                  done,
    input  logic                  clr,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  out_cnt,
`ifdef SC_PROD_CYCLE_CNT_EN
    output logic [CNT_WIDTH-1:0]  out_len,
`endif
    output logic                  overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic b;
    logic inc;

    generate
        if (MODE == 2) begin : g_xor
            assign b = Xs[0] ^ Xs[1];
        end else if (MODE == 1) begin : g_or
            assign b = |Xs;
        end else begin : g_and
            assign b = &Xs;
        end
    endgenerate

    assign inc = b & en;

    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 vld_q, vld_d;
    logic                 ovr_q, ovr_d;
    logic                 cap;
    logic                 take;

    assign cap  = done & ~clr;
    // A capture may replace the held result only if it is empty or leaving this edge.
    assign take = cap & (~vld_q | out_ready);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (done) begin
            acc_d = CNT_WIDTH'(inc);
        end else if (inc && (acc_q != CNT_MAX)) begin
            acc_d = acc_q + CNT_ONE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (clr) begin
            cnt_d = '0;
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end else if (cap) begin
            if (take) begin
                cnt_d = acc_q;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_cnt   = cnt_q;
    assign overrun   = ovr_q;

`ifdef SC_PROD_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] lacc_q, lacc_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;

    always_comb begin
        lacc_d = lacc_q;
        if (clr) begin
            lacc_d = '0;
        end else if (done) begin
            lacc_d = CNT_WIDTH'(en);
        end else if (en && (lacc_q != CNT_MAX)) begin
            lacc_d = lacc_q + CNT_ONE;
        end
    end

    // Length travels with the count: same capture/clear conditions.
    always_comb begin
        len_d = len_q;
        if (clr) begin
            len_d = '0;
        end else if (take) begin
            len_d = lacc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lacc_q <= '0;
            len_q  <= '0;
        end else begin
            lacc_q <= lacc_d;
            len_q  <= len_d;
        end
    end

    assign out_len = len_q;
`endif

endmodule

// File: tb/tb_sc_prod_ctr.sv
// Scoreboard bench for sc_prod_ctr: A = MODE0/2 inputs/16 bit, B = MODE1/2 inputs/4 bit.
module tb_sc_prod_ctr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_na, ena, da, cla, ra;
    logic [1:0] xa;
    logic       va, ova;
    logic [15:0] cnta;

    logic       rst_nb, enb, db, clb, rb;
    logic [1:0] xb;
    logic       vb, ovb;
    logic [3:0] cntb;

`ifdef SC_PROD_CYCLE_CNT_EN
    logic [15:0] lena;
    logic [3:0]  lenb;
    int qlb[$];
`endif

    int qa[$];
    int qb[$];
    int checks = 0;
    int failures = 0;

    sc_prod_ctr #(.NUM_INPUTS(2), .CNT_WIDTH(16), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_na), .en(ena), .Xs(xa), .done(da), .clr(cla),
        .out_ready(ra), .out_valid(va), .out_cnt(cnta),
`ifdef SC_PROD_CYCLE_CNT_EN
        .out_len(lena),
`endif
        .overrun(ova)
    );

    sc_prod_ctr #(.NUM_INPUTS(2), .CNT_WIDTH(4), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_nb), .en(enb), .Xs(xb), .done(db), .clr(clb),
        .out_ready(rb), .out_valid(vb), .out_cnt(cntb),
`ifdef SC_PROD_CYCLE_CNT_EN
        .out_len(lenb),
`endif
        .overrun(ovb)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop on every accepted transfer (sampled on the falling edge)
    always @(negedge clk) begin
        int e;
        if (rst_na && va && ra) begin
            if (qa.size() == 0) chk("A_unexpected_xfer", 1, 0);
            else begin
                e = qa.pop_front();
                chk("A_out_cnt", int'(cnta), e);
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (rst_nb && vb && rb) begin
            if (qb.size() == 0) chk("B_unexpected_xfer", 1, 0);
            else begin
                e = qb.pop_front();
                chk("B_out_cnt", int'(cntb), e);
`ifdef SC_PROD_CYCLE_CNT_EN
                e = qlb.pop_front();
                chk("B_out_len", int'(lenb), e);
`endif
            end
        end
    end

    task automatic ca(input logic [1:0] x, input logic d, input logic c);
        xa = x; da = d; cla = c;
        @(posedge clk); #1;
    endtask

    task automatic can(input logic [1:0] x, input int n);
        for (int i = 0; i < n; i++) ca(x, 1'b0, 1'b0);
    endtask

    task automatic cb(input logic [1:0] x, input logic d, input logic e);
        xb = x; db = d; enb = e;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_na = 0; ena = 1; da = 0; cla = 0; ra = 1; xa = 2'b00;
        rst_nb = 0; enb = 0; db = 0; clb = 0; rb = 1; xb = 2'b01;
        #3;
        chk("A_rst_valid", int'(va), 0);
        chk("A_rst_cnt", int'(cnta), 0);
        chk("A_rst_ovr", int'(ova), 0);
        chk("B_rst_valid", int'(vb), 0);
        chk("B_rst_cnt", int'(cntb), 0);
        @(posedge clk); #1;
        rst_na = 1; rst_nb = 1;
        can(2'b00, 2);

        // A: period of 256, bit0 high 128 cycles, bit1 high 64 of those -> 64
        qa.push_back(0);
        for (int i = 0; i < 256; i++) begin
            ca({(i < 64) ? 1'b1 : 1'b0, (i < 128) ? 1'b1 : 1'b0}, (i == 0) ? 1'b1 : 1'b0, 1'b0);
            if (i == 0) chk("A_first_valid", int'(va), 1);
            if (i == 1) chk("A_first_drop", int'(va), 0);
        end
        qa.push_back(64);
        ca(2'b00, 1'b1, 1'b0);
        chk("A_p1_valid", int'(va), 1);
        chk("A_p1_cnt", int'(cnta), 64);
        chk("A_p1_ovr", int'(ova), 0);
        ca(2'b00, 1'b0, 1'b0);
        chk("A_p1_one_cycle", int'(va), 0);

        // A: stall across two captures (10 then 20) -> 10 held, overrun
        qa.push_back(0);
        ca(2'b11, 1'b1, 1'b0);
        ca(2'b11, 1'b0, 1'b0);
        ra = 0;
        can(2'b11, 8);
        qa.push_back(10);
        ca(2'b11, 1'b1, 1'b0);
        chk("A_ovf_first_cnt", int'(cnta), 10);
        can(2'b11, 19);
        ca(2'b00, 1'b1, 1'b0);
        chk("A_ovf_held_cnt", int'(cnta), 10);
        chk("A_ovf_valid", int'(va), 1);
        chk("A_ovf_flag", int'(ova), 1);
        ra = 1;
        ca(2'b00, 1'b0, 1'b0);
        chk("A_ovf_xfer_valid", int'(va), 0);
        chk("A_ovf_sticky", int'(ova), 1);
        ca(2'b00, 1'b0, 1'b1);
        chk("A_clr_ovr", int'(ova), 0);

        // A: clr together with done after 5 ones
        can(2'b11, 5);
        ca(2'b11, 1'b1, 1'b1);
        chk("A_clrdone_valid", int'(va), 0);
        can(2'b11, 3);
        qa.push_back(3);
        ca(2'b00, 1'b1, 1'b0);
        chk("A_after_clr_cnt", int'(cnta), 3);
        ca(2'b00, 1'b0, 1'b0);

        // A: async reset mid-period while holding a result with overrun
        can(2'b11, 2);
        ra = 0;
        ca(2'b00, 1'b1, 1'b0);
        ca(2'b00, 1'b1, 1'b0);
        chk("A_pre_rst_valid", int'(va), 1);
        #2 rst_na = 0;
        #1;
        chk("A_async_valid", int'(va), 0);
        chk("A_async_cnt", int'(cnta), 0);
        chk("A_async_ovr", int'(ova), 0);
        @(posedge clk); #1;
        rst_na = 1; ra = 1;
        can(2'b00, 2);

        // B: MODE1, bit on the done cycle belongs to the next period; saturation at 15
        cb(2'b01, 1'b0, 1'b0);
        qb.push_back(0);
`ifdef SC_PROD_CYCLE_CNT_EN
        qlb.push_back(0);
`endif
        cb(2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cb(2'b01, 1'b0, 1'b0);
        qb.push_back(1);
`ifdef SC_PROD_CYCLE_CNT_EN
        qlb.push_back(1);
`endif
        cb(2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cb(2'b01, 1'b0, 1'b1);
        qb.push_back(15);
`ifdef SC_PROD_CYCLE_CNT_EN
        qlb.push_back(15);
`endif
        cb(2'b01, 1'b1, 1'b0);
        chk("B_sat_cnt", int'(cntb), 15);
        cb(2'b01, 1'b0, 1'b0);
        cb(2'b01, 1'b0, 1'b0);
        qb.push_back(0);
`ifdef SC_PROD_CYCLE_CNT_EN
        qlb.push_back(0);
`endif
        cb(2'b01, 1'b1, 1'b0);
        chk("B_en0_done_valid", int'(vb), 1);
        cb(2'b00, 1'b0, 1'b0);
        cb(2'b00, 1'b0, 1'b0);
        chk("B_ovr", int'(ovb), 0);

        chk("A_queue_empty", qa.size(), 0);
        chk("B_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
